// File: rtl/stream_demux_1to4_pkg.sv
// rtl/stream_demux_1to4_pkg.sv - shared constants and slice helper for the 1:4 stream demux
package stream_demux_1to4_pkg;

  localparam int NCH  = 4;
  localparam int SELW = 2;

  // Bit offset of channel k inside a packed per-channel bus of the given width.
  function automatic int slice_offset(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output register slice with wrapping pop counter
module demux_slot #(
  parameter int WIDTH = 8,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    cnt
);

  logic pop;

  assign pop = out_valid && out_ready;

  // Slot register: a load always wins (covers the pop-and-reload full-throughput case);
  // a pop alone empties the slot while the data word is left untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      data_out  <= data_in;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered-word counter, wraps naturally at 2^CW.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stream_demux_1to4.sv
// rtl/stream_demux_1to4.sv - registered 1-to-4 valid/ready stream demultiplexer
module stream_demux_1to4
  import stream_demux_1to4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SELW-1:0]      sel,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*CW-1:0]    xfer_cnt
);

  logic           accept;
  logic [NCH-1:0] load;

  // Ready depends only on the addressed slot, so a stalled channel never blocks the others.
  always_comb begin
    in_ready = !out_valid[sel] || out_ready[sel];
    accept   = in_valid && in_ready;
    load     = '0;
    load[sel] = accept;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH),
      .CW    (CW)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[k]),
      .data_in   (in_data),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .data_out  (out_data[slice_offset(k, WIDTH) +: WIDTH]),
      .cnt       (xfer_cnt[slice_offset(k, CW) +: CW])
    );
  end

endmodule
